// File: rtl/midi_rx_parser.sv
// midi_rx_parser: MIDI receive front end.
//   2-FF synchroniser -> oversampling UART -> running-status parser ->
//   channel filter -> message FIFO with valid/ready head. Realtime bytes
//   (F8h..FFh) bypass the FIFO on sys_real/sys_real_dat.
// Optional feature macro: MIDI_VEL0_NOTEOFF_EN (note-on with velocity 0 is
//   rewritten to note-off with velocity 40h before it enters the FIFO).
module midi_rx_parser #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 31250,
    parameter int FIFO_DEPTH = 8,
    parameter int CH_MASK_W  = 16
) (
    input  logic                          CLOCK_25,
    input  logic                          iRST_N,
    input  logic                          midi_rxd,
    input  logic [CH_MASK_W-1:0]          ch_mask,
    output logic                          msg_valid,
    input  logic                          msg_ready,
    output logic [7:0]                    msg_status,
    output logic [6:0]                    msg_data1,
    output logic [6:0]                    msg_data2,
    output logic                          sys_real,
    output logic [7:0]                    sys_real_dat,
    output logic                          framing_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {P_IDLE, P_RUN, P_SYSEX} parse_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; [1] is the usable line, [2] its previous value
    // for falling-edge detection. Resets to the idle (high) level.
    // ------------------------------------------------------------------
    logic [2:0] rxd_sync;
    logic       rxd_s;
    logic       rxd_prev;

    // Shift the asynchronous line through the synchroniser chain
    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) rxd_sync <= 3'b111;
        else         rxd_sync <= {rxd_sync[1:0], midi_rxd};
    end

    assign rxd_s    = rxd_sync[1];
    assign rxd_prev = rxd_sync[2];

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    uart_state_t u_state, u_next;
    logic [CW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          half_hit, full_hit;
    logic          byte_done;

    assign half_hit = (timer == CW'(HALF - 1));
    assign full_hit = (timer == CW'(DIV - 1));

    // UART next-state and stop-bit decisions
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        u_next      = u_state;
        byte_done   = 1'b0;
        framing_err = 1'b0;
        unique case (u_state)
            U_IDLE:  if (rxd_prev && !rxd_s) u_next = U_START;
            U_START: if (half_hit) u_next = rxd_s ? U_IDLE : U_DATA;
            U_DATA:  if (full_hit && bit_idx == 3'd7) u_next = U_STOP;
            U_STOP: begin
                if (full_hit) begin
                    u_next = U_IDLE;
                    if (rxd_s) byte_done   = 1'b1;
                    else       framing_err = 1'b1;
                end
            end
            default: u_next = U_IDLE;
        endcase
    end

    // UART state register, bit timer and LSB-first shift register
    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!iRST_N) begin
            u_state <= U_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            u_state <= u_next;
            if (u_state == U_IDLE || u_next != u_state || (u_state == U_DATA && full_hit))
                timer <= '0;
            else
                timer <= timer + CW'(1);
            if (u_state == U_START)
                bit_idx <= '0;
            if (u_state == U_DATA && full_hit) begin
                shift   <= {rxd_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Running-status parser and channel filter
    // ------------------------------------------------------------------
    parse_state_t p_state, p_next;
    logic [7:0]  run_status;
    logic        have_d1;
    logic [6:0]  d1_hold;
    logic        two_data;
    logic        is_data;
    logic        msg_done;
    logic [7:0]  m_status;
    logic [6:0]  m_d1, m_d2;
    logic [15:0] mask_ext;
    logic        accept;
    logic        push;
    logic [21:0] push_word;

    assign two_data = !(run_status[7:4] == 4'hC || run_status[7:4] == 4'hD);
    assign is_data  = byte_done && !shift[7] && (p_state == P_RUN);
    assign msg_done = is_data && (!two_data || have_d1);

    // Parser next state: realtime bytes leave it untouched
    always_comb begin
        p_next = p_state;
        if (byte_done && shift < 8'hF8) begin
            if (shift >= 8'hF0)  p_next = (shift == 8'hF0) ? P_SYSEX : P_IDLE;
            else if (shift[7])   p_next = P_RUN;
        end
    end

    // Assemble the completed message and decide whether the channel passes
    always_comb begin
        m_status = run_status;
        m_d1     = two_data ? d1_hold : shift[6:0];
        m_d2     = two_data ? shift[6:0] : 7'd0;
`ifdef MIDI_VEL0_NOTEOFF_EN
        if (run_status[7:4] == 4'h9 && m_d2 == 7'd0) begin
            m_status = {4'h8, run_status[3:0]};
            m_d2     = 7'h40;
        end
`endif
        mask_ext                = '0;
        mask_ext[CH_MASK_W-1:0] = ch_mask;
        accept                  = mask_ext[run_status[3:0]];
    end

    // Parser registers, FIFO push request and realtime output
    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            p_state      <= P_IDLE;
            run_status   <= '0;
            have_d1      <= 1'b0;
            d1_hold      <= '0;
            push         <= 1'b0;
            push_word    <= '0;
            sys_real     <= 1'b0;
            sys_real_dat <= '0;
        end else begin
            p_state  <= p_next;
            push     <= msg_done && accept;
            sys_real <= byte_done && (shift >= 8'hF8);
            if (msg_done)
                push_word <= {m_status, m_d1, m_d2};
            if (byte_done && shift >= 8'hF8)
                sys_real_dat <= shift;
            if (byte_done && shift[7] && shift < 8'hF0) begin
                run_status <= shift;
                have_d1    <= 1'b0;
            end else if (byte_done && shift[7] && shift < 8'hF8) begin
                run_status <= '0;
                have_d1    <= 1'b0;
            end else if (is_data) begin
                if (msg_done) begin
                    have_d1 <= 1'b0;
                end else begin
                    d1_hold <= shift[6:0];
                    have_d1 <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Message FIFO
    // ------------------------------------------------------------------
    logic [21:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, pop, do_push;
    logic [21:0] head;

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign msg_valid  = (fifo_level != '0);
    assign pop        = msg_valid && msg_ready;
    assign do_push    = push && (!full || pop);

    // Message storage write port
    always_ff @(posedge CLOCK_25) begin
        // NOTE: storage has no reset; pointers alone define what is valid.
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    // FIFO pointers and overflow pulse
    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            overflow <= push && full && !pop;
        end
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign msg_status = msg_valid ? head[21:14] : 8'd0;
    assign msg_data1  = msg_valid ? head[13:7]  : 7'd0;
    assign msg_data2  = msg_valid ? head[6:0]   : 7'd0;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Self-checking bench for midi_rx_parser: directed scenarios plus random
// byte streams, checked against a byte-level reference model of MIDI parsing.
module tb_midi_rx_parser;

    localparam int CLK_HZ = 25000000;
    localparam int BAUD   = 1250000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int DEPTH  = 8;
    localparam int MW     = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          midi_rxd = 1'b1;
    logic [MW-1:0] ch_mask = '1;
    logic          msg_valid;
    logic          msg_ready = 1'b1;
    logic [7:0]    msg_status;
    logic [6:0]    msg_data1, msg_data2;
    logic          sys_real;
    logic [7:0]    sys_real_dat;
    logic          framing_err;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    midi_rx_parser #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .CH_MASK_W(MW)
    ) dut (
        .CLOCK_25(clk), .iRST_N(rst_n), .midi_rxd(midi_rxd), .ch_mask(ch_mask),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_status(msg_status),
        .msg_data1(msg_data1), .msg_data2(msg_data2), .sys_real(sys_real),
        .sys_real_dat(sys_real_dat), .framing_err(framing_err),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_rs_valid = 0;
    logic [7:0]  m_rs = 0;
    logic [6:0]  m_data[$];
    logic [21:0] exp_fifo[$];
    logic [7:0]  exp_rt[$];
    int          exp_ovf = 0, exp_ferr = 0;

    int          ovf_cnt = 0, ferr_cnt = 0, valid_cycles = 0;
    logic [21:0] last_pop = 0;
    int          rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

    task automatic model_byte(input logic [7:0] b);
        int         need;
        int         ch;
        logic [7:0] st;
        logic [6:0] d1, d2;
        if (b >= 8'hF8) begin
            exp_rt.push_back(b);
        end else if (b >= 8'hF0) begin
            m_rs_valid = 0;
            m_data.delete();
        end else if (b[7]) begin
            m_rs = b;
            m_rs_valid = 1;
            m_data.delete();
        end else if (m_rs_valid) begin
            m_data.push_back(b[6:0]);
            need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
            if (m_data.size() == need) begin
                st = m_rs;
                d1 = m_data[0];
                d2 = (need == 2) ? m_data[1] : 7'd0;
                m_data.delete();
`ifdef MIDI_VEL0_NOTEOFF_EN
                if (st[7:4] == 4'h9 && d2 == 7'd0) begin
                    st = {4'h8, st[3:0]};
                    d2 = 7'h40;
                end
`endif
                ch = int'(st[3:0]);
                if (ch < MW && ch_mask[ch]) begin
                    if (exp_fifo.size() < DEPTH) exp_fifo.push_back({st, d1, d2});
                    else exp_ovf++;
                end
            end
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (msg_valid) begin
                valid_cycles++;
                if (exp_fifo.size() > 0)
                    check("msg_head", {msg_status, msg_data1, msg_data2}, exp_fifo[0]);
                else
                    check("msg_unexpected", {msg_status, msg_data1, msg_data2}, 0);
                if (msg_ready) begin
                    last_pop = {msg_status, msg_data1, msg_data2};
                    if (exp_fifo.size() > 0) void'(exp_fifo.pop_front());
                end
            end
            if (sys_real) begin
                if (exp_rt.size() > 0) check("rt_dat", sys_real_dat, exp_rt.pop_front());
                else                   check("rt_unexpected", sys_real_dat, 0);
            end
            if (overflow)    ovf_cnt++;
            if (framing_err) ferr_cnt++;
        end
    end

    // msg_ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            msg_ready = (rdy_mode == 2) ? ($urandom_range(3) != 0) : (rdy_mode == 1);
        end
    end

    // watchdog
    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog cycle budget exceeded");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 0;
        midi_rxd = 1;
        m_rs_valid = 0;
        m_data.delete();
        exp_fifo.delete();
        exp_rt.delete();
        ticks(3);
        check("rst_valid", msg_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_head", {msg_status, msg_data1, msg_data2}, 0);
        check("rst_pulses", {sys_real, framing_err, overflow}, 0);
        check("rst_rtdat", sys_real_dat, 0);
        rst_n = 1;
        ticks(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1);
        if (stop_ok) model_byte(b);
        else         exp_ferr++;
        midi_rxd = 0;
        ticks(DIV);
        for (int i = 0; i < 8; i++) begin
            midi_rxd = b[i];
            ticks(DIV);
        end
        midi_rxd = stop_ok;
        ticks(DIV);
        midi_rxd = 1;
        ticks(stop_ok ? 2 : 2 * DIV);
    endtask

    task automatic settle_and_check(input string tag);
        ticks(4 * DIV);
        check({tag, "_fifo_drained"}, exp_fifo.size(), 0);
        check({tag, "_rt_drained"}, exp_rt.size(), 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_ovf"}, ovf_cnt, exp_ovf);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int kind;
        logic [7:0] st;
        do_reset();

        // single note-on, valid for exactly one cycle with ready held high
        ch_mask = 16'hFFFF; rdy_mode = 1; valid_cycles = 0;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        settle_and_check("note_on");
        check("note_on_valid_cycles", valid_cycles, 1);
        check("note_on_word", last_pop, {8'h90, 7'h3C, 7'h64});

        // running status on channel 1
        ch_mask = 16'h0002; valid_cycles = 0;
        send_byte(8'h91); send_byte(8'h40); send_byte(8'h10);
        send_byte(8'h42); send_byte(8'h20);
        settle_and_check("running");
        check("running_count", valid_cycles, 2);
        check("running_last", last_pop, {8'h91, 7'h42, 7'h20});

        // realtime byte inside a message
        ch_mask = 16'hFFFF; valid_cycles = 0;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
        settle_and_check("realtime");
        check("realtime_dat", sys_real_dat, 8'hF8);
        check("realtime_msg", last_pop, {8'h90, 7'h3C, 7'h64});

        // channel filter: rejected, then accepted
        ch_mask = 16'h0000; valid_cycles = 0;
        send_byte(8'hC5); send_byte(8'h07);
        settle_and_check("filter_off");
        check("filter_off_count", valid_cycles, 0);
        ch_mask = 16'h0020;
        send_byte(8'hC5); send_byte(8'h07);
        settle_and_check("filter_on");
        check("filter_on_msg", last_pop, {8'hC5, 7'h07, 7'h00});

        // overflow: ready held low, DEPTH+1 note-ons
        ch_mask = 16'hFFFF; rdy_mode = 0;
        ticks(2);
        for (int i = 0; i <= DEPTH; i++) begin
            send_byte(8'h92); send_byte(7'(i + 1)); send_byte(7'(i + 20));
        end
        ticks(4 * DIV);
        check("ovf_level", fifo_level, DEPTH);
        check("ovf_pulses", ovf_cnt, exp_ovf);
        check("ovf_one", exp_ovf, 1);
        rdy_mode = 1;
        settle_and_check("ovf_drain");
        check("ovf_last", last_pop, {8'h92, 7'(DEPTH), 7'(DEPTH + 19)});

        // framing error, then glitch shorter than half a bit
        valid_cycles = 0;
        send_byte(8'h90, 0);
        midi_rxd = 0; ticks(3); midi_rxd = 1; ticks(2 * DIV);
        settle_and_check("framing");
        check("framing_no_msg", valid_cycles, 0);

        // velocity-zero note-on
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h00);
        settle_and_check("vel0");
`ifdef MIDI_VEL0_NOTEOFF_EN
        check("vel0_msg", last_pop, {8'h80, 7'h3C, 7'h40});
`else
        check("vel0_msg", last_pop, {8'h90, 7'h3C, 7'h00});
`endif

        // reset mid-message and mid-byte discards everything partial
        send_byte(8'h93); send_byte(8'h3C);
        midi_rxd = 0; ticks(3 * DIV);
        do_reset();
        valid_cycles = 0;
        send_byte(8'h64);
        settle_and_check("reset_mid");
        check("reset_mid_no_msg", valid_cycles, 0);
        send_byte(8'h93); send_byte(8'h3C); send_byte(8'h64);
        settle_and_check("reset_after");
        check("reset_after_msg", last_pop, {8'h93, 7'h3C, 7'h64});

        // random streams
        rdy_mode = 2;
        for (int batch = 0; batch < 5; batch++) begin
            ch_mask = MW'($urandom);
            for (int n = 0; n < 12; n++) begin
                kind = $urandom_range(9);
                if (kind <= 3) begin
                    st = {1'b1, 3'($urandom_range(6)), 4'($urandom)};
                    send_byte(st);
                    send_byte(7'($urandom));
                    if (st[7:4] != 4'hC && st[7:4] != 4'hD) send_byte(7'($urandom));
                end else if (kind <= 5) begin
                    send_byte(7'($urandom));
                end else if (kind == 6) begin
                    send_byte(8'hF8 + 8'($urandom_range(7)));
                end else if (kind == 7) begin
                    send_byte(8'hF0); send_byte(7'($urandom));
                    send_byte(7'($urandom)); send_byte(8'hF7);
                end else begin
                    send_byte(8'hF1 + 8'($urandom_range(6)));
                end
            end
            settle_and_check("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_rx_parser.md
# midi_rx_parser

Parametrised MIDI receive front end: oversampling UART, running-status message parser, per-channel filter and a message FIFO with a valid/ready output. It replaces the separate byte-level UART plus downstream byte counting in the synthesizer top level, and feeds the note and controller decoders with complete, channel-filtered 3-byte messages. Realtime bytes bypass the FIFO.

## Interface
- CLK_HZ, 25000000, system clock frequency.
- BAUD, 31250, serial bit rate; DIV = CLK_HZ/BAUD (800 at defaults), integer, at least 16.
- FIFO_DEPTH, 8, message FIFO entries, power of two, at least 2.
- CH_MASK_W, 16, width of the channel accept mask (1..16; channels at or above CH_MASK_W are rejected).

Ports:
- CLOCK_25  in  1  system clock; all logic on its rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- midi_rxd  in  1  serial input; idle high; asynchronous to CLOCK_25.
- ch_mask  in  CH_MASK_W  bit n=1 accepts channel-voice messages on channel n.
- msg_valid  out  1  FIFO head valid.
- msg_ready  in  1  consumer accepts head when msg_valid=1.
- msg_status  out  8  status byte of head (8nh..Enh).
- msg_data1  out  7  first data byte; msg_data2 out 7 second data byte (0 for 1-data messages).
- sys_real  out  1  one-cycle pulse per realtime byte (F8h..FFh).
- sys_real_dat  out  8  last realtime byte; held until next.
- framing_err  out  1  one-cycle pulse on bad stop bit.
- overflow  out  1  one-cycle pulse when a message is dropped because FIFO full.
- fifo_level  out  clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Reset: all outputs 0; parser in IDLE, running status cleared, FIFO empty, UART idle.
- Input: 2-FF synchroniser on midi_rxd.
- UART states: IDLE, START, DATA, STOP. IDLE to START on synchronised falling edge. START: after DIV/2 cycles sample; high means glitch, return to IDLE; low enters DATA. DATA: 8 samples every DIV cycles, LSB first. STOP: sample after DIV; high means byte_done; low means framing_err pulse, byte discarded, return to IDLE (rearm only after line seen high).
- Parser, per received byte:
  - F8h..FFh: sys_real pulse, sys_real_dat loaded; parser state and partial message untouched.
  - 80h..EFh: latch running status, clear data count; expect 1 data byte for Cn/Dn, else 2.
  - F0h: clear running status, enter SYSEX; all data bytes ignored until any non-realtime status. F1h..F7h: clear running status, ignore.
  - Data byte (bit7=0) with running status: store; when expected count reached, message complete, count resets (running status kept). Data byte without running status or in SYSEX: discarded.
- Complete message pushed only if channel (low nibble) < CH_MASK_W and ch_mask[channel]=1.
- FIFO: pop when msg_valid and msg_ready. Push when full without simultaneous pop: message dropped, overflow pulse. Push and pop same cycle when full: both occur, no overflow, level unchanged.
- msg_data2 written 0 for Cn/Dn messages.

## Timing
- byte_done at the stop-bit sample cycle S; complete message pushed at S+1; msg_valid/level visible at S+2.
- sys_real pulse at S+1.
- framing_err pulse at the stop-bit sample cycle.
- Head outputs stable while msg_valid=1 and msg_ready=0; next entry presented the cycle after a pop.
- Reset asserted mid-byte or mid-message: immediate return to reset state; partial byte and message lost.
- Sample points drift at most 1 cycle per bit relative to the ideal centre (integer DIV).

## Configuration
- MIDI_VEL0_NOTEOFF_EN defined: a note-on (9nh) with data2=0 is pushed as 8nh with data2=40h; running status stays 9nh.
- Undefined: pushed unchanged as 9nh with data2=0.

## Test plan
- Send 90h 3Ch 64h at 31250 baud, ch_mask=FFFFh, msg_ready=1 -> one message 90h/3Ch/64h; msg_valid high exactly one cycle.
- Send 91h 40h 10h 42h 20h (running status), ch_mask=0002h -> two messages 91h/40h/10h and 91h/42h/20h.
- Send 90h 3Ch F8h 64h -> sys_real pulse with sys_real_dat=F8h; message 90h/3Ch/64h still delivered.
- Send C5h 07h with ch_mask=0000h -> nothing pushed; with ch_mask=0020h -> message C5h/07h/00h.
- Hold msg_ready=0, send FIFO_DEPTH+1 note-ons -> fifo_level=FIFO_DEPTH, one overflow pulse; drain returns first FIFO_DEPTH messages in order.
- Byte with stop bit forced low -> framing_err pulse, no message; 90h 3Ch 00h -> 80h/3Ch/40h with MIDI_VEL0_NOTEOFF_EN, 90h/3Ch/00h without.
